// File: rtl/image_fifo_line_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | image_fifo_line_ctrl_if : video in/out, external FIFO port and status      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface image_fifo_line_ctrl_if #(
    parameter int DATA_W = 10,
    parameter int LVL_W  = 12
);
    logic              in_fv;
    logic              in_lv;
    logic [DATA_W-1:0] in_data;
    logic [LVL_W-1:0]  line_len;
    logic [DATA_W-1:0] fifo_Data;
    logic              fifo_WrEn;
    logic              fifo_RdEn;
    logic              fifo_Reset;
    logic [DATA_W-1:0] fifo_Q;
    logic              fifo_Empty;
    logic              fifo_Full;
    logic              out_fv;
    logic              out_de;
    logic [DATA_W-1:0] out_data;
    logic [LVL_W-1:0]  level;
    logic              overflow;
    logic              underflow;

    modport slave (
        input  in_fv, in_lv, in_data, line_len, fifo_Q, fifo_Empty, fifo_Full,
        output fifo_Data, fifo_WrEn, fifo_RdEn, fifo_Reset,
        output out_fv, out_de, out_data, level, overflow, underflow
    );

    modport master (
        output in_fv, in_lv, in_data, line_len, fifo_Q, fifo_Empty, fifo_Full,
        input  fifo_Data, fifo_WrEn, fifo_RdEn, fifo_Reset,
        input  out_fv, out_de, out_data, level, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/image_fifo_line_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | image_fifo_line_ctrl : writes input lines into an external FIFO and reads  |
// | them back as fixed-length output lines separated by horizontal blanking.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module image_fifo_line_ctrl #(
    parameter int DATA_W    = 10,
    parameter int LVL_W     = 12,
    parameter int RD_THRESH = 16,
    parameter int H_BLANK   = 8
) (
    input  wire logic             Clock,
    input  wire logic             Reset,
    image_fifo_line_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FLUSH = 3'd1,
        WAIT  = 3'd2,
        LINE  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_fv_d;
    logic              r_lv_d;
    logic              r_rst_d1;
    logic              r_rst_d2;
    logic              r_flush_cnt;
    logic              r_out_de;
    logic              r_overflow;
    logic              r_underflow;
    logic [LVL_W-1:0]  r_level;
    logic [LVL_W-1:0]  r_lines_pending;
    logic [LVL_W-1:0]  r_rd_cnt;
    logic [LVL_W-1:0]  r_gap_cnt;

    logic              w_fifo_rst;
    logic              w_wr;
    logic              w_rd;
    logic              w_fv_rise;
    logic              w_lv_fall;
    logic              w_last_rd;
    logic              w_start_line;
    logic              w_out_fv;
    logic [DATA_W-1:0] w_pix;

    // Flush is held one extra cycle past reset release so the FIFO comes up clean
    assign w_fifo_rst   = r_rst_d1 | r_rst_d2 | (r_state == FLUSH);
    assign w_wr         = bus.in_fv & bus.in_lv & ~bus.fifo_Full & ~w_fifo_rst;
    assign w_rd         = (r_state == LINE) & ~bus.fifo_Empty & ~Reset;
    assign w_fv_rise    = bus.in_fv & ~r_fv_d;
    assign w_lv_fall    = bus.in_fv & r_lv_d & ~bus.in_lv;
    assign w_last_rd    = w_rd & (r_rd_cnt == bus.line_len - LVL_W'(1));
    assign w_start_line = (bus.line_len != '0) &
                          ((r_lines_pending != '0) || (r_level >= LVL_W'(RD_THRESH)));
    assign w_pix        = bus.in_data;

    always_comb begin
        w_next   = r_state;
        w_out_fv = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_fv_rise) w_next = FLUSH;
            end
            FLUSH: begin
                if (r_flush_cnt) w_next = WAIT;
            end
            WAIT: begin
                w_out_fv = 1'b1;
                if (w_start_line)
                    w_next = LINE;
                else if (~bus.in_fv && (r_lines_pending == '0) && (r_level == '0))
                    w_next = IDLE;
            end
            LINE: begin
                w_out_fv = 1'b1;
                if (w_last_rd) w_next = GAP;
            end
            GAP: begin
                w_out_fv = 1'b1;
                if (r_gap_cnt == LVL_W'(H_BLANK - 1)) w_next = WAIT;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state         <= IDLE;
            r_fv_d          <= 1'b0;
            r_lv_d          <= 1'b0;
            r_rst_d1        <= 1'b1;
            r_rst_d2        <= 1'b1;
            r_flush_cnt     <= 1'b0;
            r_out_de        <= 1'b0;
            r_overflow      <= 1'b0;
            r_underflow     <= 1'b0;
            r_level         <= '0;
            r_lines_pending <= '0;
            r_rd_cnt        <= '0;
            r_gap_cnt       <= '0;
        end else begin
            r_state  <= w_next;
            r_fv_d   <= bus.in_fv;
            r_lv_d   <= bus.in_lv;
            r_rst_d1 <= 1'b0;
            r_rst_d2 <= r_rst_d1;
            r_out_de <= w_rd;
            r_flush_cnt <= (r_state == FLUSH) ? ~r_flush_cnt : 1'b0;
            r_gap_cnt   <= (r_state == GAP) ? r_gap_cnt + LVL_W'(1) : '0;

            if (w_fifo_rst)
                r_level <= '0;
            else if (w_wr && !w_rd)
                r_level <= r_level + LVL_W'(1);
            else if (!w_wr && w_rd)
                r_level <= r_level - LVL_W'(1);

            // A line ending in the same cycle as a new input line closing nets to zero
            if (w_fifo_rst)
                r_lines_pending <= '0;
            else if (w_lv_fall && !w_last_rd)
                r_lines_pending <= r_lines_pending + LVL_W'(1);
            else if (!w_lv_fall && w_last_rd && (r_lines_pending != '0))
                r_lines_pending <= r_lines_pending - LVL_W'(1);

            if (r_state == WAIT && w_next == LINE)
                r_rd_cnt <= '0;
            else if (w_rd)
                r_rd_cnt <= r_rd_cnt + LVL_W'(1);

            if (bus.in_fv && bus.in_lv && (bus.fifo_Full || w_fifo_rst))
                r_overflow <= 1'b1;
            if (r_state == LINE && bus.fifo_Empty)
                r_underflow <= 1'b1;
        end
    end

    assign bus.fifo_Data  = w_pix;
    assign bus.fifo_WrEn  = w_wr;
    assign bus.fifo_RdEn  = w_rd;
    assign bus.fifo_Reset = w_fifo_rst;
    assign bus.out_fv     = w_out_fv;
    assign bus.out_de     = r_out_de;
    assign bus.out_data   = bus.fifo_Q;
    assign bus.level      = r_level;
    assign bus.overflow   = r_overflow;
    assign bus.underflow  = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_image_fifo_line_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_image_fifo_line_ctrl : directed bench with FIFO model and scoreboard    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_image_fifo_line_ctrl;

    localparam int RD_THRESH = 16;
    localparam int H_BLANK   = 8;

    logic Clock = 1'b0;
    logic Reset;

    image_fifo_line_ctrl_if #(.DATA_W(10), .LVL_W(12)) bus ();

    image_fifo_line_ctrl #(
        .DATA_W(10), .LVL_W(12), .RD_THRESH(RD_THRESH), .H_BLANK(H_BLANK)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    int          total = 0;
    int          bad   = 0;
    logic [9:0]  exp_q[$];
    logic [9:0]  fq[$];
    logic [9:0]  px = 10'h001;
    int          de_cnt = 0;
    int          low_run = 0;
    int          first_lvl = -1;
    bit          seen_de = 1'b0;
    bit          rd_seen = 1'b0;
    bit          gap_chk = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge Clock);
    endtask

    task automatic drive_px(input logic lv, input logic push);
        bus.in_lv   = lv;
        bus.in_data = lv ? px : 10'h000;
        if (lv && push) exp_q.push_back(px);
        if (lv) px = px + 10'd1;
        step();
    endtask

    task automatic new_frame();
        de_cnt  = 0;
        seen_de = 1'b0;
        rd_seen = 1'b0;
        low_run = 0;
        bus.in_fv = 1'b1;
        repeat (3) step();
    endtask

    // External FIFO: read data appears the cycle after RdEn
    always @(posedge Clock) begin
        if (bus.fifo_Reset) begin
            fq.delete();
        end else begin
            if (bus.fifo_RdEn && fq.size() != 0) bus.fifo_Q <= fq.pop_front();
            if (bus.fifo_WrEn) fq.push_back(bus.fifo_Data);
        end
        bus.fifo_Empty <= (fq.size() == 0);
    end

    always @(negedge Clock) begin
        logic [9:0] e;
        if (bus.fifo_RdEn && !rd_seen) begin
            rd_seen   = 1'b1;
            first_lvl = int'(bus.level);
        end
        if (bus.out_de) begin
            de_cnt++;
            chk("fv_during_de", 32'(bus.out_fv), 32'd1);
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_data", 32'(bus.out_data), 32'(e));
            end
            if (gap_chk && seen_de && low_run > 0)
                chk("hblank", 32'(low_run >= H_BLANK), 32'd1);
            seen_de = 1'b1;
            low_run = 0;
        end else if (seen_de) begin
            low_run++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset         = 1'b1;
        bus.in_fv     = 1'b0;
        bus.in_lv     = 1'b0;
        bus.in_data   = 10'h000;
        bus.line_len  = 12'd20;
        bus.fifo_Full = 1'b0;
        repeat (2) step();
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_unf", 32'(bus.underflow), 32'd0);
        chk("rst_fv", 32'(bus.out_fv), 32'd0);
        chk("rst_de", 32'(bus.out_de), 32'd0);
        chk("rst_rden", 32'(bus.fifo_RdEn), 32'd0);
        chk("rst_wren", 32'(bus.fifo_WrEn), 32'd0);
        chk("rst_frst", 32'(bus.fifo_Reset), 32'd1);
        Reset = 1'b0;
        step();
        chk("frst_after_release", 32'(bus.fifo_Reset), 32'd1);
        step();
        chk("frst_released", 32'(bus.fifo_Reset), 32'd0);
        chk("idle_fv", 32'(bus.out_fv), 32'd0);

        // Frame A: two 20-pixel lines, early start at threshold
        gap_chk = 1'b1;
        de_cnt = 0; seen_de = 1'b0; rd_seen = 1'b0;
        bus.in_fv = 1'b1;
        step();
        chk("A_flush1", 32'(bus.fifo_Reset), 32'd1);
        step();
        chk("A_flush2", 32'(bus.fifo_Reset), 32'd1);
        step();
        chk("A_flush_end", 32'(bus.fifo_Reset), 32'd0);
        chk("A_fv_rise", 32'(bus.out_fv), 32'd1);
        for (int i = 0; i < 20; i++) drive_px(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) drive_px(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) drive_px(1'b1, 1'b1);
        for (int i = 0; i < 5; i++)  drive_px(1'b0, 1'b0);
        bus.in_fv = 1'b0;
        for (int i = 0; i < 200 && bus.out_fv; i++) step();
        chk("A_fv_fall", 32'(bus.out_fv), 32'd0);
        chk("A_de_count", 32'(de_cnt), 32'd40);
        chk("A_first_rd_level", 32'(first_lvl), 32'(RD_THRESH + 1));
        chk("A_sb_drained", 32'(exp_q.size()), 32'd0);
        chk("A_unf", 32'(bus.underflow), 32'd0);
        chk("A_ovf", 32'(bus.overflow), 32'd0);
        chk("A_level", 32'(bus.level), 32'd0);
        gap_chk = 1'b0;

        // Frame C: simultaneous write and read at level 7
        bus.line_len = 12'd4;
        new_frame();
        for (int i = 0; i < 7; i++) drive_px(1'b1, 1'b1);
        drive_px(1'b0, 1'b0);
        for (int i = 0; i < 20 && !bus.fifo_RdEn; i++) step();
        chk("C_rd_started", 32'(bus.fifo_RdEn), 32'd1);
        chk("C_level_before", 32'(bus.level), 32'd7);
        drive_px(1'b1, 1'b1);
        chk("C_level_wr_rd", 32'(bus.level), 32'd7);
        drive_px(1'b0, 1'b0);
        bus.in_fv = 1'b0;
        for (int i = 0; i < 200 && bus.out_fv; i++) step();
        chk("C_fv_fall", 32'(bus.out_fv), 32'd0);
        chk("C_de_count", 32'(de_cnt), 32'd8);
        chk("C_sb_drained", 32'(exp_q.size()), 32'd0);

        // Frame B: line started via lines_pending, stalls, then completes
        bus.line_len = 12'd20;
        new_frame();
        for (int i = 0; i < 5; i++)  drive_px(1'b1, 1'b1);
        for (int i = 0; i < 12; i++) drive_px(1'b0, 1'b0);
        chk("B_unf", 32'(bus.underflow), 32'd1);
        chk("B_de_stall", 32'(de_cnt), 32'd5);
        for (int i = 0; i < 15; i++) drive_px(1'b1, 1'b1);
        drive_px(1'b0, 1'b0);
        chk("B_lp_hold", 32'(dut.r_lines_pending), 32'd1);
        step();
        chk("B_de_line", 32'(de_cnt), 32'd20);
        chk("B_unf_sticky", 32'(bus.underflow), 32'd1);

        // Reset mid-line at rd_cnt 9
        for (int i = 0; i < 60; i++) begin
            if (dut.r_rd_cnt == 12'd9 && bus.fifo_RdEn) break;
            drive_px(1'b1, 1'b1);
        end
        chk("R_at_cnt9", 32'(dut.r_rd_cnt), 32'd9);
        Reset     = 1'b1;
        bus.in_lv = 1'b0;
        #1;
        chk("R_rden_now", 32'(bus.fifo_RdEn), 32'd0);
        step();
        chk("R_rden", 32'(bus.fifo_RdEn), 32'd0);
        chk("R_de", 32'(bus.out_de), 32'd0);
        chk("R_frst", 32'(bus.fifo_Reset), 32'd1);
        chk("R_state", 32'(dut.r_state), 32'd0);
        chk("R_level", 32'(bus.level), 32'd0);
        chk("R_lp", 32'(dut.r_lines_pending), 32'd0);
        chk("R_rdcnt", 32'(dut.r_rd_cnt), 32'd0);
        chk("R_unf", 32'(bus.underflow), 32'd0);
        chk("R_fv", 32'(bus.out_fv), 32'd0);
        exp_q.delete();
        Reset     = 1'b0;
        bus.in_fv = 1'b0;
        repeat (3) step();

        // Frame D: dropped pixels while full, line_len 0 never reads
        bus.line_len = 12'd0;
        new_frame();
        for (int i = 0; i < 20; i++) begin
            bus.fifo_Full = (i >= 5 && i < 8);
            bus.in_lv     = 1'b1;
            bus.in_data   = px;
            #1;
            chk("D_wren", 32'(bus.fifo_WrEn), 32'(!(i >= 5 && i < 8)));
            if (!bus.fifo_Full) exp_q.push_back(px);
            px = px + 10'd1;
            step();
        end
        bus.fifo_Full = 1'b0;
        drive_px(1'b0, 1'b0);
        chk("D_ovf", 32'(bus.overflow), 32'd1);
        chk("D_level", 32'(bus.level), 32'd17);
        chk("D_state_wait", 32'(dut.r_state), 32'd2);
        repeat (10) step();
        chk("D_ovf_sticky", 32'(bus.overflow), 32'd1);
        chk("D_no_rd", 32'(rd_seen), 32'd0);
        chk("D_still_wait", 32'(dut.r_state), 32'd2);
        chk("D_level_hold", 32'(bus.level), 32'd17);
        Reset = 1'b1;
        step();
        Reset     = 1'b0;
        bus.in_fv = 1'b0;
        step();
        chk("D_ovf_cleared", 32'(bus.overflow), 32'd0);
        chk("D_level_cleared", 32'(bus.level), 32'd0);
        exp_q.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/image_fifo_line_ctrl.md
IMAGE_FIFO_LINE_CTRL -- requirements
Module: image_fifo_line_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high (ports Clock and Reset).
REQ-002 Parameter DATA_W, default 10, SHALL set the pixel word width.
REQ-003 Parameter LVL_W, default 12, SHALL set the width of level, line_len and the internal counters.
REQ-004 Parameter RD_THRESH, default 16, SHALL set the minimum FIFO level at which a line read starts early.
REQ-005 Parameter H_BLANK, default 8, SHALL set the number of de-low cycles after each output line.
REQ-006 Ports SHALL be, one per line:
  Clock  in  1  system clock
  Reset  in  1  synchronous active-high reset
  in_fv  in  1  input frame valid
  in_lv  in  1  input line valid
  in_data  in  DATA_W  input pixel
  line_len  in  LVL_W  pixels per output line, static within a frame
  fifo_Data  out  DATA_W  FIFO write data, equal to in_data
  fifo_WrEn  out  1  FIFO write enable
  fifo_RdEn  out  1  FIFO read enable
  fifo_Reset  out  1  FIFO flush
  fifo_Q  in  DATA_W  FIFO read data, valid 1 cycle after fifo_RdEn
  fifo_Empty  in  1  FIFO empty
  fifo_Full  in  1  FIFO full
  out_fv  out  1  output frame valid
  out_de  out  1  output data enable
  out_data  out  DATA_W  output pixel
  level  out  LVL_W  tracked FIFO occupancy
  overflow  out  1  sticky: an input pixel was dropped
  underflow  out  1  sticky: a read stalled mid-line

Function
REQ-007 fifo_WrEn SHALL equal in_fv & in_lv & ~fifo_Full & ~fifo_Reset (combinational).
REQ-008 A pixel with in_fv & in_lv & (fifo_Full | fifo_Reset) SHALL be dropped and SHALL set overflow.
REQ-009 level SHALL increment on WrEn only, decrement on RdEn only, hold on both or neither, and clear on fifo_Reset.
REQ-010 lines_pending SHALL increment on an in_lv falling edge (registered compare) while in_fv=1, and decrement on the last RdEn of an output line; when both occur in the same cycle, lines_pending SHALL hold.
REQ-011 The FSM states SHALL be IDLE, FLUSH, WAIT, LINE and GAP.
REQ-012 IDLE: on an in_fv rising edge -> FLUSH; out_fv=0.
REQ-013 FLUSH: fifo_Reset=1 for exactly 2 cycles, level and lines_pending cleared -> WAIT; out_fv goes to 1 on entering WAIT.
REQ-014 WAIT: if line_len!=0 and (lines_pending!=0 or level>=RD_THRESH) -> LINE, with rd_cnt cleared; if in_fv=0 and lines_pending=0 and level=0 -> IDLE, with out_fv=0.
REQ-015 LINE: fifo_RdEn = ~fifo_Empty; rd_cnt increments per RdEn; the RdEn at rd_cnt=line_len-1 ends the line -> GAP.
REQ-016 LINE with fifo_Empty=1 SHALL stall (RdEn=0) and set underflow; the line SHALL resume without loss.
REQ-017 GAP: RdEn=0 for H_BLANK cycles -> WAIT.
REQ-018 out_de SHALL be fifo_RdEn delayed 1 cycle, and out_data SHALL be fifo_Q; out_data SHALL be don't-care when out_de=0.
REQ-019 An in_fv rising edge outside IDLE SHALL NOT flush; the new frame SHALL be appended to the FIFO.
REQ-020 overflow and underflow SHALL clear only on Reset.

Reset
REQ-021 When Reset=1 the block SHALL enter IDLE, and on the next edge: level=0, lines_pending=0, rd_cnt=0, overflow=0, underflow=0, out_fv=0, out_de=0, fifo_RdEn=0, fifo_WrEn=0, fifo_Reset=1.
REQ-022 fifo_Reset SHALL also assert for the cycle after Reset deasserts.
REQ-023 A Reset asserted mid-line SHALL abort the line with no further RdEn.

Verification
REQ-024 Frame of 2 lines x line_len=20, in_lv 20 cycles high with 10 cycles gap -> FLUSH 2 cycles; line 1 reads start when level reaches 16; exactly 40 out_de pulses with data in order; 8 de-low cycles after each line; out_fv falls after the last pixel.
REQ-025 line_len=20, in_lv held high 5 cycles then low, level=5 -> LINE entered via lines_pending; 5 pixels out, then stall with underflow=1; the next 15 written pixels complete the line.
REQ-026 fifo_Full forced high for 3 cycles during in_lv -> 3 pixels dropped, overflow=1 and stays 1 until Reset; level does not count the dropped pixels.
REQ-027 WrEn and RdEn in the same cycle with level=7 -> level stays 7; an in_lv fall coinciding with end of line -> lines_pending unchanged.
REQ-028 Reset pulsed at rd_cnt=9 of 20 -> next cycle RdEn=0, out_de=0, fifo_Reset=1, state IDLE, all counters 0.
REQ-029 line_len=0 with data written -> FSM stays in WAIT and never asserts RdEn.
